// File: rtl/lc3_mem_arbiter_if.sv
// Bundle between the LC-3 requesters (cpu, debug/loader), the arbiter and the memory array.
// The slave modport is the arbiter side; master is the requester/memory side.
interface lc3_mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    logic          dbg_halt;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// CPU/debug arbiter for the LC-3 memory array; LC3_ARB_RR_EN selects round-robin ties, otherwise debug has priority.
// Latency: mem_en 1 cycle and ack 2 cycles after the grant edge; requesters hold req until ack, no other backpressure.
module lc3_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3_mem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic          r_owner;
    logic          r_busy;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_cpu_ack;
    logic          r_dbg_ack;

    logic          w_cpu_elig;
    logic          w_dbg_elig;
    logic          w_grant_dbg;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_cpu_elig = bus.cpu_req & ~bus.dbg_halt;
    assign w_dbg_elig = bus.dbg_req;

`ifdef LC3_ARB_RR_EN
    // On a tie the side that did not win last time goes first.
    assign w_grant_dbg = w_dbg_elig & (~w_cpu_elig | ~r_owner);
`else
    assign w_grant_dbg = w_dbg_elig;
`endif

    assign w_sel_we    = w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_owner     <= 1'b1;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    r_dbg_ack <= 1'b0;
                    if (w_cpu_elig | w_dbg_elig) begin
                        r_owner     <= w_grant_dbg;
                        r_we        <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= ~r_owner;
                    r_dbg_ack <= r_owner;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_dbg_ack <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_dbg_ack <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dbg_ack   = r_dbg_ack;

    // Memory data is valid only in the RESP cycle, which is exactly when ack is high.
    assign bus.cpu_rdata = (r_cpu_ack && !r_we) ? bus.mem_rdata : '0;
    assign bus.dbg_rdata = (r_dbg_ack && !r_we) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with a synchronous-read memory model; honours LC3_ARB_RR_EN for tie order.
module tb_lc3_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef LC3_ARB_RR_EN
    localparam bit FIRST_DBG = 1'b0;
`else
    localparam bit FIRST_DBG = 1'b1;
`endif

    lc3_mem_arbiter_if #(.AW(16), .DW(16)) bus();

    lc3_mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [15:0] pre_dat;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_dat;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic clear_reqs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0; bus.dbg_wdata = 16'h0;
        bus.dbg_halt = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_addr = a; pre_dat = d; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.busy, bus.owner} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en/we/cack/dack/busy/owner=%b required 000001",
                     {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.busy, bus.owner});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr/wdata=%h required 00000000", {bus.mem_addr, bus.mem_wdata});
        end
        n_checks++;
        if ({bus.cpu_rdata, bus.dbg_rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 00000000", {bus.cpu_rdata, bus.dbg_rdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        preload(16'h3000, 16'h1234);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000;
        @(negedge clk); // cycle 1
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.busy, bus.cpu_ack, bus.owner} !== 5'b10100) begin
            n_fail++;
            $display("FAIL cpu_read_c1: got en/we/busy/ack/owner=%b required 10100",
                     {bus.mem_en, bus.mem_we, bus.busy, bus.cpu_ack, bus.owner});
        end
        n_checks++;
        if (bus.mem_addr !== 16'h3000) begin
            n_fail++;
            $display("FAIL cpu_read_addr: got %h required 3000", bus.mem_addr);
        end
        @(negedge clk); // cycle 2
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.mem_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL cpu_read_c2_ack: got cack/dack/en=%b required 100", {bus.cpu_ack, bus.dbg_ack, bus.mem_en});
        end
        n_checks++;
        if ({bus.cpu_rdata, bus.dbg_rdata} !== {16'h1234, 16'h0000}) begin
            n_fail++;
            $display("FAIL cpu_read_data: got cpu/dbg rdata=%h required 12340000", {bus.cpu_rdata, bus.dbg_rdata});
        end
        bus.cpu_req = 1'b0;
        @(negedge clk); // cycle 3
        n_checks++;
        if ({bus.busy, bus.cpu_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_read_c3: got busy/ack=%b required 00", {bus.busy, bus.cpu_ack});
        end
    endtask

    task automatic test_dbg_write_cpu_read();
        logic        got;
        int          lat;
        logic [15:0] rd;
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0040; bus.dbg_wdata = 16'hBEEF;
        @(negedge clk); // cycle 1
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.owner, bus.mem_addr, bus.mem_wdata} !== {3'b111, 16'h0040, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL dbg_write_c1: got en/we/owner=%b addr=%h wdata=%h required 111 0040 beef",
                     {bus.mem_en, bus.mem_we, bus.owner}, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk); // cycle 2
        n_checks++;
        if ({bus.dbg_ack, bus.cpu_ack, bus.dbg_rdata} !== {2'b10, 16'h0000}) begin
            n_fail++;
            $display("FAIL dbg_write_ack: got dack/cack=%b rdata=%h required 10 0000",
                     {bus.dbg_ack, bus.cpu_ack}, bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
        got = 1'b0; lat = 0; rd = 16'h0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                got = 1'b1; lat = i; rd = bus.cpu_rdata;
            end
        end
        bus.cpu_req = 1'b0;
        n_checks++;
        if (!got || lat > 5) begin
            n_fail++;
            $display("FAIL cpu_after_dbg_latency: got ack=%b after %0d cycles required ack within 5", got, lat);
        end
        n_checks++;
        if (rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL cpu_after_dbg_data: got %h required beef", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [15:0] exp_addr;
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        @(negedge clk);
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0040;
        @(negedge clk); // cycle 1
        exp_addr = FIRST_DBG ? 16'h0040 : 16'h3000;
        n_checks++;
        if ({bus.owner, bus.mem_addr} !== {FIRST_DBG, exp_addr}) begin
            n_fail++;
            $display("FAIL tie_first_grant: got owner=%b addr=%h required owner=%b addr=%h",
                     bus.owner, bus.mem_addr, FIRST_DBG, exp_addr);
        end
        @(negedge clk); // cycle 2
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata} !==
            (FIRST_DBG ? {2'b01, 16'h0000, 16'hBEEF} : {2'b10, 16'h1234, 16'h0000})) begin
            n_fail++;
            $display("FAIL tie_first_ack: got cack/dack=%b cpu=%h dbg=%h",
                     {bus.cpu_ack, bus.dbg_ack}, bus.cpu_rdata, bus.dbg_rdata);
        end
        if (FIRST_DBG) bus.dbg_req = 1'b0; else bus.cpu_req = 1'b0;
        @(negedge clk); // cycle 3
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL tie_gap: got cack/dack/busy=%b required 000", {bus.cpu_ack, bus.dbg_ack, bus.busy});
        end
        @(negedge clk); // cycle 4
        n_checks++;
        if ({bus.mem_en, bus.owner} !== {1'b1, ~FIRST_DBG}) begin
            n_fail++;
            $display("FAIL tie_second_grant: got en/owner=%b required 1%b", {bus.mem_en, bus.owner}, ~FIRST_DBG);
        end
        @(negedge clk); // cycle 5
        n_checks++;
        if ({bus.cpu_ack, bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata} !==
            (FIRST_DBG ? {2'b10, 16'h1234, 16'h0000} : {2'b01, 16'h0000, 16'hBEEF})) begin
            n_fail++;
            $display("FAIL tie_second_ack: got cack/dack=%b cpu=%h dbg=%h",
                     {bus.cpu_ack, bus.dbg_ack}, bus.cpu_rdata, bus.dbg_rdata);
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:1] pat;
        logic       data_ok;
        pat = '0; data_ok = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            pat[i] = bus.cpu_ack;
            if (bus.cpu_ack && bus.cpu_rdata !== 16'h1234) data_ok = 1'b0;
        end
        bus.cpu_req = 1'b0;
        n_checks++;
        if (pat !== 5'b10010) begin
            n_fail++;
            $display("FAIL back_to_back_acks: got cycles5..1=%b required 10010", pat);
        end
        n_checks++;
        if (data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_data: got a read other than 1234 required 1234 on each ack");
        end
        @(negedge clk);
    endtask

    task automatic test_halt();
        int bad;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000;
        @(negedge clk); // cycle 1: halt rises mid-access
        bus.dbg_halt = 1'b1;
        @(negedge clk); // cycle 2
        n_checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL halt_no_abort: got ack=%b rdata=%h required 1 1234", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cpu_ack !== 1'b0 || bus.mem_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_blocks_cpu: got %0d cycles with ack/mem_en high required 0", bad);
        end
        bus.dbg_halt = 1'b0;
        @(negedge clk); // cycle 1
        n_checks++;
        if ({bus.mem_en, bus.owner} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_release_grant: got en/owner=%b required 10", {bus.mem_en, bus.owner});
        end
        @(negedge clk); // cycle 2
        n_checks++;
        if (bus.cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_release_ack: got %b required 1", bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3000;
        @(negedge clk); // ACCESS
        n_checks++;
        if (bus.mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_access_en: got %b required 1", bus.mem_en);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.busy, bus.owner,
             bus.mem_addr, bus.mem_wdata, bus.cpu_rdata} !== {6'b000001, 48'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got en/we/cack/dack/busy/owner=%b addr=%h wdata=%h rdata=%h required 000001 0 0 0",
                     {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.busy, bus.owner},
                     bus.mem_addr, bus.mem_wdata, bus.cpu_rdata);
        end
        reset = 1'b0;
        @(negedge clk); // re-issued request, cycle 1
        n_checks++;
        if ({bus.mem_en, bus.cpu_ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_reissue_c1: got en/ack=%b required 10", {bus.mem_en, bus.cpu_ack});
        end
        @(negedge clk); // cycle 2
        n_checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL rst_reissue_ack: got ack=%b rdata=%h required 1 1234", bus.cpu_ack, bus.cpu_rdata);
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        pre_en = 1'b0; pre_addr = 16'h0; pre_dat = 16'h0;
        clear_reqs();
        test_reset();
        test_cpu_read();
        test_dbg_write_cpu_read();
        test_tie();
        test_back_to_back();
        test_halt();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end
endmodule
